uart_bus_ctrl: RTL and testbench
================================

Name: uart_bus_ctrl

Overview:
- Memory-mapped register front end and sequencer for the UART receive path (and the matching transmit FIFO).
- Decodes single-beat bus requests into control, status, RX-read and TX-write accesses.
- Drives the RX block's active and read-enable strobes, then waits for the RX read-done pulse, with a timeout.
- Sits between the system bus slave port and the UART RX/TX blocks.

Parameters:
- TIMEOUT, 16, cycles to wait in RX_WAIT for rx_done_i before an error response.
- BAUD_RST, 16'd868, reset value of baud_div_o (100 MHz / 115200).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  synchronous active-low reset
- req_i  in  1  bus request; held high until ack_o
- we_i  in  1  1 = write, 0 = read; valid with req_i
- addr_i  in  2  register select: 0 CTRL, 1 STATUS, 2 RXDATA, 3 TXDATA
- wdata_i  in  32  write data
- ack_o  out  1  one-cycle response strobe
- err_o  out  1  error flag; valid only with ack_o
- rdata_o  out  32  read data; valid with ack_o
- baud_div_o  out  16  to RX/TX baud generators
- rx_active_o  out  1  RX enable
- rx_rd_en_o  out  1  one-cycle RX read request
- rx_rdata_i  in  8  RX data
- rx_done_i  in  1  RX read-done pulse
- rx_full_i  in  1  RX FIFO status
- rx_empty_i  in  1  RX FIFO status
- tx_wr_o  out  1  one-cycle TX FIFO write
- tx_wdata_o  out  8  TX FIFO write data
- tx_full_i  in  1  TX FIFO status
- tx_empty_i  in  1  TX FIFO status

Behaviour:
- Reset (rstn_i low at a clock edge): state IDLE; ack_o, err_o, rx_rd_en_o, tx_wr_o = 0; rdata_o = 0; baud_div_o = BAUD_RST; rx_active_o = 0; tx_wdata_o = 0; ovf flag = 0; timeout counter = 0.
- Reset mid-transaction aborts the access with no ack_o. Reset has priority over every other event.
- CTRL register:
  - bits [15:0] = baud_div, bit 16 = rx_active, bit 17 = tx_en (stored only); other bits read 0.
  - A write of 0 to baud_div is ignored; the field keeps its old value and err_o = 1.
- STATUS register (read-only except bit 4):
  - bit 0 rx_empty, bit 1 rx_full, bit 2 tx_empty, bit 3 tx_full, bit 4 ovf.
  - ovf is sticky: set in any cycle where rx_active_o and rx_full_i are both 1; cleared by writing 1 to bit 4.
  - If set and clear occur in the same cycle, set wins.
- States: IDLE, RX_WAIT, RESP.
  - IDLE: on req_i, decode and go to RESP, except an RXDATA read with rx_empty_i = 0.
  - RXDATA read, rx_empty_i = 0: pulse rx_rd_en_o for 1 cycle; go to RX_WAIT; clear the counter.
  - RX_WAIT, rx_done_i = 1: latch rdata_o = {24'b0, rx_rdata_i}, err 0, go to RESP.
  - RX_WAIT, counter reaches TIMEOUT-1 with no rx_done_i: rdata_o = 0, err 1, go to RESP. Otherwise increment the counter.
  - RESP: ack_o = 1 for exactly one cycle with the latched err/rdata, then go to IDLE.
- req_i is not sampled while in RESP. The earliest back-to-back access is accepted the cycle after ack_o.
- Latency from req_i to ack_o:
  - CTRL/STATUS/TXDATA: 2 cycles.
  - RXDATA: 3 + wait cycles, where wait = cycles from rx_rd_en_o to rx_done_i.
- Error and side-effect cases:
  - RXDATA read while rx_empty_i = 1: no rx_rd_en_o; ack with rdata 0, err 1.
  - TXDATA write with tx_full_i = 0: pulse tx_wr_o 1 cycle with tx_wdata_o = wdata_i[7:0]; err 0.
  - TXDATA write with tx_full_i = 1: no tx_wr_o; err 1.
  - TXDATA read, or a write to RXDATA: ack, rdata 0, err 1, no side effects.
- Register writes take effect in the cycle ack_o is asserted.
- rx_active_o follows CTRL bit 16 directly. Clearing it during RX_WAIT does not abort the wait.

Test Plan:
- Reset then read CTRL -> ack 2 cycles after req; rdata 0x0000_0364; rx_active_o = 0.
- Write CTRL 0x0001_01B2 then read -> baud_div_o = 0x01B2; rx_active_o = 1; readback 0x0001_01B2. Write baud 0 -> err 1, baud stays 0x01B2.
- RX not empty, model returns 0xA5 with rx_done_i 2 cycles after rx_rd_en_o -> single rx_rd_en_o pulse; ack 5 cycles after req; rdata 0xA5; err 0.
- RXDATA read with rx_empty_i = 1 -> no rx_rd_en_o; err 1, rdata 0. With rx_done_i never asserted -> err 1 exactly TIMEOUT cycles after entering RX_WAIT.
- TX write 0x3C with tx_full_i = 0 -> tx_wr_o single pulse, tx_wdata_o 0x3C. With tx_full_i = 1 -> no tx_wr_o, err 1.
- rx_active_o = 1 and rx_full_i pulsed -> STATUS bit 4 = 1. Write 0x10 -> cleared. Clear concurrent with rx_full_i -> stays 1. rstn_i low during RX_WAIT -> no ack, state IDLE.

Source files
------------

// File: rtl/uart_bus_ctrl.sv
// Register front end and RX/TX sequencer for the UART: decodes single-beat bus
// accesses, strobes the RX read path with a timeout, and feeds the TX FIFO.
module uart_bus_ctrl #(
    parameter int          TIMEOUT  = 16,
    parameter logic [15:0] BAUD_RST = 16'd868
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [15:0] baud_div_o,
    output logic        rx_active_o,
    output logic        rx_rd_en_o,
    input  logic [7:0]  rx_rdata_i,
    input  logic        rx_done_i,
    input  logic        rx_full_i,
    input  logic        rx_empty_i,
    output logic        tx_wr_o,
    output logic [7:0]  tx_wdata_o,
    input  logic        tx_full_i,
    input  logic        tx_empty_i,
    output logic [1:0]  dbg_state_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_RXDATA = 2'd2;
    localparam logic [1:0] A_TXDATA = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RX_WAIT = 2'd1,
        S_RESP    = 2'd2
    } state_t;

    state_t      r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic        r_ack, w_ack;
    logic        r_err, w_err;
    logic [31:0] r_rdata, w_rdata;
    logic [15:0] r_baud, w_baud;
    logic        r_rx_active, w_rx_active;
    logic        r_tx_en, w_tx_en;
    logic        r_ovf, w_ovf;
    logic        r_rx_rd_en, w_rx_rd_en;
    logic        r_tx_wr, w_tx_wr;
    logic [7:0]  r_tx_wdata, w_tx_wdata;
    logic        r_pend_ctrl, w_pend_ctrl;
    logic        r_pend_clr, w_pend_clr;
    logic [17:0] r_pend_data, w_pend_data;
    logic        w_unused;

    assign w_unused = ^wdata_i[31:18];

    // Register writes are held pending during RESP so they land with ack_o.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_ack       = 1'b0;
        w_err       = r_err;
        w_rdata     = r_rdata;
        w_baud      = r_baud;
        w_rx_active = r_rx_active;
        w_tx_en     = r_tx_en;
        w_ovf       = r_ovf;
        w_rx_rd_en  = 1'b0;
        w_tx_wr     = 1'b0;
        w_tx_wdata  = r_tx_wdata;
        w_pend_ctrl = r_pend_ctrl;
        w_pend_clr  = r_pend_clr;
        w_pend_data = r_pend_data;

        case (r_state)
            S_IDLE: begin
                if (req_i && !r_ack) begin
                    w_state     = S_RESP;
                    w_err       = 1'b0;
                    w_rdata     = 32'd0;
                    w_pend_ctrl = 1'b0;
                    w_pend_clr  = 1'b0;
                    case (addr_i)
                        A_CTRL: begin
                            if (we_i) begin
                                w_pend_ctrl = 1'b1;
                                w_pend_data = wdata_i[17:0];
                                w_err       = (wdata_i[15:0] == 16'd0);
                            end else begin
                                w_rdata = {14'd0, r_tx_en, r_rx_active, r_baud};
                            end
                        end
                        A_STATUS: begin
                            if (we_i) begin
                                w_pend_clr = wdata_i[4];
                            end else begin
                                w_rdata = {27'd0, r_ovf, tx_full_i, tx_empty_i,
                                           rx_full_i, rx_empty_i};
                            end
                        end
                        A_RXDATA: begin
                            if (we_i || rx_empty_i) begin
                                w_err = 1'b1;
                            end else begin
                                w_rx_rd_en = 1'b1;
                                w_cnt      = '0;
                                w_state    = S_RX_WAIT;
                            end
                        end
                        default: begin
                            if (!we_i || tx_full_i) begin
                                w_err = 1'b1;
                            end else begin
                                w_tx_wr    = 1'b1;
                                w_tx_wdata = wdata_i[7:0];
                            end
                        end
                    endcase
                end
            end
            S_RX_WAIT: begin
                if (rx_done_i) begin
                    w_rdata = {24'd0, rx_rdata_i};
                    w_err   = 1'b0;
                    w_state = S_RESP;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_rdata = 32'd0;
                    w_err   = 1'b1;
                    w_state = S_RESP;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_RESP: begin
                w_ack   = 1'b1;
                w_state = S_IDLE;
                if (r_pend_ctrl) begin
                    if (r_pend_data[15:0] != 16'd0) begin
                        w_baud = r_pend_data[15:0];
                    end
                    w_rx_active = r_pend_data[16];
                    w_tx_en     = r_pend_data[17];
                    w_pend_ctrl = 1'b0;
                end
                if (r_pend_clr) begin
                    w_ovf      = 1'b0;
                    w_pend_clr = 1'b0;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Overflow set is evaluated last so it beats a same-cycle clear.
        if (r_rx_active && rx_full_i) begin
            w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'd0;
            r_baud      <= BAUD_RST;
            r_rx_active <= 1'b0;
            r_tx_en     <= 1'b0;
            r_ovf       <= 1'b0;
            r_rx_rd_en  <= 1'b0;
            r_tx_wr     <= 1'b0;
            r_tx_wdata  <= 8'd0;
            r_pend_ctrl <= 1'b0;
            r_pend_clr  <= 1'b0;
            r_pend_data <= 18'd0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_ack       <= w_ack;
            r_err       <= w_err;
            r_rdata     <= w_rdata;
            r_baud      <= w_baud;
            r_rx_active <= w_rx_active;
            r_tx_en     <= w_tx_en;
            r_ovf       <= w_ovf;
            r_rx_rd_en  <= w_rx_rd_en;
            r_tx_wr     <= w_tx_wr;
            r_tx_wdata  <= w_tx_wdata;
            r_pend_ctrl <= w_pend_ctrl;
            r_pend_clr  <= w_pend_clr;
            r_pend_data <= w_pend_data;
        end
    end

    assign ack_o       = r_ack;
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign baud_div_o  = r_baud;
    assign rx_active_o = r_rx_active;
    assign rx_rd_en_o  = r_rx_rd_en;
    assign tx_wr_o     = r_tx_wr;
    assign tx_wdata_o  = r_tx_wdata;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Self-checking bench for uart_bus_ctrl: directed vector table, hand-written
// RX/overflow/reset sequences, and randomized accesses against a register model.
module tb_uart_bus_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  addr_i = 2'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        ack_o, err_o;
    logic [31:0] rdata_o;
    logic [15:0] baud_div_o;
    logic        rx_active_o, rx_rd_en_o, tx_wr_o;
    logic [7:0]  tx_wdata_o;
    logic [7:0]  rx_rdata_i = 8'd0;
    logic        rx_done_i = 1'b0;
    logic        rx_full_i = 1'b0;
    logic        rx_empty_i = 1'b1;
    logic        tx_full_i = 1'b0;
    logic        tx_empty_i = 1'b1;
    logic [1:0]  dbg_state_o;

    uart_bus_ctrl #(.TIMEOUT(TIMEOUT), .BAUD_RST(16'd868)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .err_o(err_o),
        .rdata_o(rdata_o), .baud_div_o(baud_div_o), .rx_active_o(rx_active_o),
        .rx_rd_en_o(rx_rd_en_o), .rx_rdata_i(rx_rdata_i), .rx_done_i(rx_done_i),
        .rx_full_i(rx_full_i), .rx_empty_i(rx_empty_i), .tx_wr_o(tx_wr_o),
        .tx_wdata_o(tx_wdata_o), .tx_full_i(tx_full_i), .tx_empty_i(tx_empty_i),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- RX responder and strobe monitors ----------------
    int        rsp_delay = 0;       // -1: never answer
    logic [7:0] rsp_data = 8'h00;
    int        rd_cnt = 0;
    int        tx_cnt = 0;
    logic [7:0] tx_last = 8'h00;

    initial begin
        forever begin
            @(negedge clk_i);
            if (rx_rd_en_o) begin
                rd_cnt++;
                if (rsp_delay >= 0) begin
                    repeat (rsp_delay) @(negedge clk_i);
                    rx_done_i  = 1'b1;
                    rx_rdata_i = rsp_data;
                    @(negedge clk_i);
                    rx_done_i  = 1'b0;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (tx_wr_o) begin
            tx_cnt++;
            tx_last = tx_wdata_o;
        end
    end

    // ---------------- bus driver ----------------
    task automatic bus_access(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                              input logic full_pulse,
                              output logic [31:0] rdata, output logic err, output int lat);
        logic got;
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
        lat = 0; got = 1'b0; rdata = 32'd0; err = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk_i);
            lat++;
            if (full_pulse) rx_full_i = (lat == 1);
            if (ack_o) begin
                got = 1'b1; rdata = rdata_o; err = err_o;
            end
        end
        req_i = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL ack_timeout: got no ack expected ack within 100 cycles");
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_baud;
    logic        m_rx_active, m_tx_en, m_ovf;

    task automatic model_access(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                                input logic rx_empty, input logic tx_full, input logic tx_empty,
                                input int dly, input logic [7:0] rxd,
                                output logic [31:0] er, output logic ee, output int el,
                                output int erd, output int etx);
        er = 32'd0; ee = 1'b0; el = 2; erd = 0; etx = 0;
        if (addr == 2'd0) begin
            if (we) begin
                if (wdata[15:0] == 16'd0) ee = 1'b1;
                else m_baud = wdata[15:0];
                m_rx_active = wdata[16];
                m_tx_en     = wdata[17];
            end else begin
                er = {14'd0, m_tx_en, m_rx_active, m_baud};
            end
        end else if (addr == 2'd1) begin
            if (we) begin
                if (wdata[4]) m_ovf = 1'b0;
            end else begin
                er = {27'd0, m_ovf, tx_full, tx_empty, 1'b0, rx_empty};
            end
        end else if (addr == 2'd2) begin
            if (we || rx_empty) ee = 1'b1;
            else begin
                erd = 1;
                if (dly < 0) begin ee = 1'b1; el = 2 + TIMEOUT; end
                else begin er = {24'd0, rxd}; el = 3 + dly; end
            end
        end else begin
            if (!we || tx_full) ee = 1'b1;
            else etx = 1;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        rx_empty;
        logic        tx_full;
        logic        tx_empty;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_tx;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, rd0, tx0, acks;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat, e_rd, e_tx;
        logic        r_we, r_rxe, r_txf, r_txe;
        logic [1:0]  r_addr;
        logic [31:0] r_wdata;
        logic [7:0]  r_rxd;
        int          r_dly;

        vecs[0]  = '{1'b0, 2'd0, 32'h0,          1'b1, 1'b0, 1'b1, 32'h0000_0364, 1'b0, 2, 0, 0};
        vecs[1]  = '{1'b1, 2'd0, 32'h0001_01B2,  1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 2, 0, 0};
        vecs[2]  = '{1'b0, 2'd0, 32'h0,          1'b1, 1'b0, 1'b1, 32'h0001_01B2, 1'b0, 2, 0, 0};
        vecs[3]  = '{1'b1, 2'd0, 32'h0001_0000,  1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 2, 0, 0};
        vecs[4]  = '{1'b0, 2'd0, 32'h0,          1'b1, 1'b0, 1'b1, 32'h0001_01B2, 1'b0, 2, 0, 0};
        vecs[5]  = '{1'b0, 2'd1, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0000_0009, 1'b0, 2, 0, 0};
        vecs[6]  = '{1'b1, 2'd2, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 2, 0, 0};
        vecs[7]  = '{1'b0, 2'd3, 32'h0,          1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 2, 0, 0};
        vecs[8]  = '{1'b0, 2'd2, 32'h0,          1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 2, 0, 0};
        vecs[9]  = '{1'b1, 2'd3, 32'h0000_003C,  1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2, 0, 0};
        vecs[10] = '{1'b1, 2'd3, 32'hFFFF_FF3C,  1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 2, 0, 1};

        // reset
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        check("rst_ack", {31'd0, ack_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_baud", {16'd0, baud_div_o}, 32'd868);
        check("rst_rx_active", {31'd0, rx_active_o}, 32'd0);
        check("rst_strobes", {30'd0, rx_rd_en_o, tx_wr_o}, 32'd0);
        check("rst_tx_wdata", {24'd0, tx_wdata_o}, 32'd0);
        check("rst_state", {30'd0, dbg_state_o}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            rx_empty_i = vecs[i].rx_empty; tx_full_i = vecs[i].tx_full; tx_empty_i = vecs[i].tx_empty;
            rd0 = rd_cnt; tx0 = tx_cnt;
            bus_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_rd", i), rd_cnt - rd0, vecs[i].exp_rd);
            check($sformatf("vec%0d_tx", i), tx_cnt - tx0, vecs[i].exp_tx);
        end
        check("tx_data_3c", {24'd0, tx_last}, 32'h3C);
        check("baud_after_table", {16'd0, baud_div_o}, 32'h01B2);
        check("rx_active_after_table", {31'd0, rx_active_o}, 32'd1);

        // RX read answered 2 cycles after the read strobe
        rx_empty_i = 1'b0; rsp_delay = 2; rsp_data = 8'hA5; rd0 = rd_cnt;
        bus_access(1'b0, 2'd2, 32'h0, 1'b0, rd, er, lat);
        check("rx_a5_rdata", rd, 32'h0000_00A5);
        check("rx_a5_err", {31'd0, er}, 32'd0);
        check("rx_a5_lat", lat, 5);
        check("rx_a5_rd_pulses", rd_cnt - rd0, 1);

        // RX read never answered
        rsp_delay = -1; rd0 = rd_cnt;
        bus_access(1'b0, 2'd2, 32'h0, 1'b0, rd, er, lat);
        check("rx_to_rdata", rd, 32'h0);
        check("rx_to_err", {31'd0, er}, 32'd1);
        check("rx_to_lat", lat, 2 + TIMEOUT);
        check("rx_to_rd_pulses", rd_cnt - rd0, 1);

        // sticky overflow: set, clear, concurrent set beats clear
        rx_empty_i = 1'b1; tx_full_i = 1'b0; tx_empty_i = 1'b1;
        @(negedge clk_i); rx_full_i = 1'b1;
        @(negedge clk_i); rx_full_i = 1'b0;
        bus_access(1'b0, 2'd1, 32'h0, 1'b0, rd, er, lat);
        check("ovf_set", rd, 32'h15);
        bus_access(1'b1, 2'd1, 32'h10, 1'b0, rd, er, lat);
        check("ovf_clr_err", {31'd0, er}, 32'd0);
        bus_access(1'b0, 2'd1, 32'h0, 1'b0, rd, er, lat);
        check("ovf_cleared", rd, 32'h05);
        bus_access(1'b1, 2'd1, 32'h10, 1'b1, rd, er, lat);
        rx_full_i = 1'b0;
        bus_access(1'b0, 2'd1, 32'h0, 1'b0, rd, er, lat);
        check("ovf_set_wins", rd, 32'h15);

        // randomized accesses against the model
        m_baud = 16'h01B2; m_rx_active = 1'b1; m_tx_en = 1'b0; m_ovf = 1'b1;
        for (int n = 0; n < 60; n++) begin
            r_we = 1'($urandom_range(0, 1));
            r_addr = 2'($urandom_range(0, 3));
            r_wdata = $urandom;
            if (r_addr == 2'd0 && $urandom_range(0, 3) == 0) r_wdata[15:0] = 16'd0;
            r_rxe = 1'($urandom_range(0, 1));
            r_txf = 1'($urandom_range(0, 1));
            r_txe = 1'($urandom_range(0, 1));
            r_dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 4));
            r_rxd = 8'($urandom);
            rx_empty_i = r_rxe; tx_full_i = r_txf; tx_empty_i = r_txe;
            rsp_delay = r_dly; rsp_data = r_rxd;
            rd0 = rd_cnt; tx0 = tx_cnt;
            model_access(r_we, r_addr, r_wdata, r_rxe, r_txf, r_txe, r_dly, r_rxd,
                         e_rdata, e_err, e_lat, e_rd, e_tx);
            bus_access(r_we, r_addr, r_wdata, 1'b0, rd, er, lat);
            check($sformatf("rnd%0d_rdata", n), rd, e_rdata);
            check($sformatf("rnd%0d_err", n), {31'd0, er}, {31'd0, e_err});
            check($sformatf("rnd%0d_lat", n), lat, e_lat);
            check($sformatf("rnd%0d_rd", n), rd_cnt - rd0, e_rd);
            check($sformatf("rnd%0d_tx", n), tx_cnt - tx0, e_tx);
            if (e_tx == 1) check($sformatf("rnd%0d_txdata", n), {24'd0, tx_last}, {24'd0, r_wdata[7:0]});
            check($sformatf("rnd%0d_baud", n), {16'd0, baud_div_o}, {16'd0, m_baud});
            check($sformatf("rnd%0d_rx_active", n), {31'd0, rx_active_o}, {31'd0, m_rx_active});
        end

        // reset while waiting for RX data aborts the access without ack
        rx_empty_i = 1'b0; rsp_delay = -1; rd0 = rd_cnt; acks = 0;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 2'd2;
        @(negedge clk_i);
        check("rst_mid_in_wait", {30'd0, dbg_state_o}, 32'd1);
        repeat (2) begin @(negedge clk_i); acks += int'(ack_o); end
        rstn_i = 1'b0;
        @(negedge clk_i); acks += int'(ack_o);
        rstn_i = 1'b1; req_i = 1'b0;
        repeat (TIMEOUT + 4) begin @(negedge clk_i); acks += int'(ack_o); end
        check("rst_mid_no_ack", acks, 0);
        check("rst_mid_state", {30'd0, dbg_state_o}, 32'd0);
        check("rst_mid_baud", {16'd0, baud_div_o}, 32'd868);
        check("rst_mid_rd_pulses", rd_cnt - rd0, 1);
        bus_access(1'b0, 2'd0, 32'h0, 1'b0, rd, er, lat);
        check("post_rst_ctrl", rd, 32'h0000_0364);
        check("post_rst_lat", lat, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
